// File: rtl/ram_sync.sv
// ram_sync: DEPTH = 2^ADDR_W by DATA_W single-port synchronous RAM with an
// internal memory address register (MAR), WAIT_STATES access wait cycles,
// a level request / ready handshake and optional post-access MAR increment.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst      synchronous active-high reset
//   a        address for MAR load / direct access
//   sa       load MAR from a (honoured in IDLE only)
//   s, e     write / read request, level, held until ready
//   inc      sampled with the request; MAR <= addr + 1 when the access completes
//   bus      shared tri-state data bus (driven only while presenting read data)
//   ready    access complete (state DONE)
//   busy     state WAIT or DONE
//   mar      current MAR value
//   err      sticky: s and e both seen high in IDLE
//   par_err  stored parity mismatch on the last read
//
// Handshake: a request is accepted in IDLE when exactly one of s/e is high.
// ready rises when the access completes and stays high while the request of
// the current op remains high; dropping it returns the block to IDLE on the
// next edge. A request dropped before completion still completes and ready
// pulses for a single cycle.
//
// Optional feature macro: RAM_PARITY_EN (per-word even parity + par_err).
module ram_sync #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a,
    input  logic              sa,
    input  logic              s,
    input  logic              e,
    input  logic              inc,
    inout  wire  [DATA_W-1:0] bus,
    output logic              ready,
    output logic              busy,
    output logic [ADDR_W-1:0] mar,
    output logic              err,
    output logic              par_err
);

    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                inc_q, inc_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Access completion (the edge that enters DONE). With zero wait states
    // acceptance and completion share one edge, so the commit uses the live
    // request values instead of the latched ones.
    logic                commit;
    logic [ADDR_W-1:0]   commit_addr;
    logic                commit_wr;
    logic [DATA_W-1:0]   commit_data;
    logic                commit_inc;
    logic [ADDR_W-1:0]   acc_addr;

`ifdef RAM_PARITY_EN
    logic                mem_par [DEPTH];
    logic                par_err_q, par_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mar_d       = mar_q;
        op_wr_d     = op_wr_q;
        addr_d      = addr_q;
        inc_d       = inc_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        commit      = 1'b0;
        commit_addr = addr_q;
        commit_wr   = op_wr_q;
        commit_data = wdata_q;
        commit_inc  = inc_q;
        acc_addr    = sa ? a : mar_q;
`ifdef RAM_PARITY_EN
        par_err_d   = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sa) mar_d = a;
                if (s && e) begin
                    err_d = 1'b1;
                end else if (s || e) begin
                    op_wr_d = s;
                    addr_d  = acc_addr;
                    inc_d   = inc;
                    if (s) wdata_d = bus;
                    wcnt_d  = WS_INIT;
`ifdef RAM_PARITY_EN
                    par_err_d = 1'b0;
`endif
                    if (WAIT_STATES == 0) begin
                        state_d     = S_DONE;
                        commit      = 1'b1;
                        commit_addr = acc_addr;
                        commit_wr   = s;
                        commit_data = bus;
                        commit_inc  = inc;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q == 4'd1) begin
                    state_d = S_DONE;
                    commit  = 1'b1;
                end
            end
            S_DONE: begin
                if (!(op_wr_q ? s : e)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            if (!commit_wr) rdata_d = mem[commit_addr];
            // Completion increment overrides any sa load on the same edge.
            if (commit_inc) mar_d = commit_addr + 1'b1;
`ifdef RAM_PARITY_EN
            if (!commit_wr) par_err_d = mem_par[commit_addr] != (^mem[commit_addr]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            mar_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            inc_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            mar_q   <= mar_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            inc_q   <= inc_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is not reset; a reset on the completing edge drops the write.
    always_ff @(posedge clk) begin
        if (!rst && commit && commit_wr) mem[commit_addr] <= commit_data;
    end

`ifdef RAM_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst && commit && commit_wr) mem_par[commit_addr] <= ^commit_data;
    end

    always_ff @(posedge clk) begin
        if (rst) par_err_q <= 1'b0;
        else     par_err_q <= par_err_d;
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign ready = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);
    assign mar   = mar_q;
    assign err   = err_q;
    assign bus   = (state_q == S_DONE && !op_wr_q && e) ? rdata_q : 'z;

endmodule

// File: tb/tb_ram_sync.sv
// Testbench for ram_sync (WAIT_STATES = 2). A transaction-level model keeps
// expected memory contents, MAR, err and par_err; every access is checked
// cycle by cycle against the expected wait/ready/bus timeline. The bus has
// pull-ups, so a released bus reads as all ones.
module tb_ram_sync;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int WS = 2;
    localparam logic [DW-1:0] BUS_Z = 8'hFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] a;
    logic          sa, s, e, inc;
    wire  [DW-1:0] bus;
    logic          ready, busy, err, par_err;
    logic [AW-1:0] mar;

    logic          bus_oe;
    logic [DW-1:0] bus_drv;

    assign bus = bus_oe ? bus_drv : 'z;
    for (genvar gi = 0; gi < DW; gi++) begin : g_pu
        pullup (bus[gi]);
    end

    ram_sync #(.DATA_W(DW), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .a(a), .sa(sa), .s(s), .e(e), .inc(inc),
        .bus(bus), .ready(ready), .busy(busy), .mar(mar), .err(err),
        .par_err(par_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] mem_m [256];
    bit            valid_m [256];
    bit            corrupt_m [256];
    logic [AW-1:0] wr_addrs [$];
    logic [AW-1:0] mar_m;
    bit            err_m;
    bit            par_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        a = '0; sa = 0; s = 0; e = 0; inc = 0; bus_oe = 0; bus_drv = '0;
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1;
        rst = 1; idle_inputs();
        repeat (cycles) @(posedge clk);
        #1 rst = 0;
        mar_m = '0; err_m = 0; par_m = 0;
    endtask

    // One complete access: drive request, walk the expected timeline, release.
    task automatic do_access(input bit wr, input bit use_sa, input logic [AW-1:0] addr_in,
                             input logic [DW-1:0] wdata, input bit inc_in, input bit early);
        logic [AW-1:0] acc;
        logic [DW-1:0] exp_rd;
        acc = use_sa ? addr_in : mar_m;
        if (use_sa) mar_m = addr_in;
        par_m = 0;
        if (wr) begin
            mem_m[acc] = wdata; corrupt_m[acc] = 0;
            if (!valid_m[acc]) begin valid_m[acc] = 1; wr_addrs.push_back(acc); end
        end
        exp_rd = mem_m[acc];
        if (!wr) par_m = corrupt_m[acc];
        if (inc_in) mar_m = acc + 1'b1;

        @(posedge clk); #1;
        a = addr_in; sa = use_sa; s = wr; e = !wr; inc = inc_in;
        bus_oe = wr; bus_drv = wdata;
        @(posedge clk); #1;   // acceptance edge passed
        sa = 0; inc = 0; bus_oe = 0; a = $urandom_range(0, 255);
        if (early) begin s = 0; e = 0; end
        for (int k = 1; k <= WS + 1; k++) begin
            @(negedge clk);
            if (k <= WS) begin
                check("ready_wait", ready, 0);
                check("busy_wait", busy, 1);
                if (k == 1 && !wr && !early) check("bus_z_wait", bus, BUS_Z);
            end else begin
                check("ready_done", ready, 1);
                check("busy_done", busy, 1);
                if (!wr && !early) check("rd_data", bus, exp_rd);
                if (wr || early) check("bus_z_done", bus, BUS_Z);
                if (!wr) check("par_err", par_err, par_m);
            end
        end
        if (!early) begin
            @(posedge clk); #1;
            s = 0; e = 0;
            @(negedge clk);
            check("ready_hold", ready, 1);
            check("bus_z_drop", bus, BUS_Z);
        end
        @(negedge clk);
        check("ready_idle", ready, 0);
        check("busy_idle", busy, 0);
        check("mar", mar, mar_m);
        check("err", err, err_m);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [AW-1:0] ra;
        bit wr, use_sa;
        rst = 1; idle_inputs();
        for (int i = 0; i < 256; i++) begin valid_m[i] = 0; corrupt_m[i] = 0; end

        // Reset then idle
        do_reset(2);
        @(negedge clk);
        check("rst_mar", mar, 0);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_par", par_err, 0);
        check("rst_bus", bus, BUS_Z);

        // Write 0xA5 to 0x10 via sa, then read it back through the MAR
        do_access(1, 1, 8'h10, 8'hA5, 0, 0);
        do_access(0, 0, 8'h00, 8'h00, 0, 0);

        // Auto-increment with wrap, then read back 0xFF
        do_access(1, 1, 8'hFF, 8'h3C, 1, 0);
        check("mar_wrap", mar, 8'h00);
        do_access(0, 1, 8'hFF, 8'h00, 0, 0);

        // Conflict: s and e together in IDLE -> err, no access
        do_access(0, 1, 8'h10, 8'h00, 0, 0);   // mar = 0x10
        @(posedge clk); #1;
        s = 1; e = 1; bus_oe = 1; bus_drv = 8'h11;
        @(posedge clk); #1;
        s = 0; e = 0; bus_oe = 0;
        err_m = 1;
        @(negedge clk);
        check("conf_err", err, 1);
        check("conf_busy", busy, 0);
        do_access(0, 0, 8'h00, 8'h00, 0, 0);   // 0x10 still holds 0xA5
        check("err_sticky", err, 1);

        // Reset in the middle of a write: word unchanged
        @(posedge clk); #1;
        a = 8'h10; sa = 1; s = 1; bus_oe = 1; bus_drv = 8'h5E;
        @(posedge clk); #1;
        sa = 0; bus_oe = 0;
        @(negedge clk);
        check("mid_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; s = 0;
        mar_m = '0; err_m = 0; par_m = 0;
        @(negedge clk);
        check("mid_busy_rst", busy, 0);
        check("mid_ready_rst", ready, 0);
        check("mid_err_rst", err, 0);
        check("mid_mar_rst", mar, 0);
        check("mid_bus", bus, BUS_Z);
        do_access(0, 1, 8'h10, 8'h00, 0, 0);

`ifdef RAM_PARITY_EN
        // Flip one stored data bit behind the parity bit's back
        dut.mem[8'h10] = dut.mem[8'h10] ^ 8'h01;
        mem_m[8'h10] = mem_m[8'h10] ^ 8'h01;
        corrupt_m[8'h10] = 1;
        do_access(0, 1, 8'h10, 8'h00, 0, 0);
        check("par_set", par_err, 1);
        do_access(0, 1, 8'hFF, 8'h00, 0, 0);
        check("par_clr", par_err, 0);
`endif

        // Randomized accesses
        for (int t = 0; t < 40; t++) begin
            wr = ($urandom_range(0, 2) == 0);
            use_sa = $urandom_range(0, 1);
            ra = $urandom_range(0, 255);
            if (!wr) begin
                if (use_sa || !valid_m[mar_m]) begin
                    use_sa = 1;
                    ra = wr_addrs[$urandom_range(0, wr_addrs.size() - 1)];
                end
            end
            do_access(wr, use_sa, ra, 8'($urandom_range(0, 254)),
                      $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
